quiz_buzzer_arbiter: RTL

QUIZ_BUZZER_ARBITER -- requirements
Module: quiz_buzzer_arbiter

---
 rtl/quiz_buzzer_pkg.sv | 26 ++
 rtl/press_qualifier.sv | 43 ++++
 rtl/quiz_buzzer_arbiter.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/quiz_buzzer_pkg.sv
// Shared definitions for the quiz buzzer arbiter: FSM encoding and sizing helpers.
// Latency: n/a (package only).
// Backpressure: n/a.
package quiz_buzzer_pkg;

    // FSM encoding, kept as plain constants so older tools accept it unchanged.
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SHOW    = 2'd1;
    localparam logic [1:0] ST_RELEASE = 2'd2;

    // Bits needed to count 0..n-1, never less than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    // Increment v, saturating at the largest value representable in w bits.
    function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
        logic [63:0] mx;
        mx = (64'd1 << w) - 64'd1;
        if ({32'd0, v} >= mx) begin
            return v;
        end
        return v + 32'd1;
    endfunction

endpackage

// File: rtl/press_qualifier.sv
// Per-team press qualifier: counts consecutive enabled high cycles of one button.
// Latency: qualify_o is combinational, asserted during the HOLD_CYCLES-th high cycle.
// Backpressure: none; dropping en_i or btn_i clears the count.
module press_qualifier
    import quiz_buzzer_pkg::*;
#(
    parameter int HOLD_CYCLES = 50_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en_i,
    input  logic btn_i,
    output logic qualify_o
);

    localparam int              CW   = cnt_w(HOLD_CYCLES);
    localparam logic [CW-1:0]   LAST = CW'(HOLD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          active;

    assign active    = en_i && btn_i;
    assign qualify_o = active && (cnt_q == LAST);

    // Count while enabled and pressed; any gap or disable restarts from zero.
    always_comb begin
        cnt_d = '0;
        if (active) begin
            cnt_d = (cnt_q == LAST) ? cnt_q : cnt_q + CW'(1);
        end
    end

    // Hold counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/quiz_buzzer_arbiter.sv
// Quiz buzzer arbiter: first team to hold its button wins, judge scores or locks out.
// Latency: winner outputs register one cycle after the qualifying cycle.
// Backpressure: none; presses outside IDLE or from locked-out teams are ignored.
module quiz_buzzer_arbiter
    import quiz_buzzer_pkg::*;
#(
    parameter int N_TEAMS     = 4,
    parameter int HOLD_CYCLES = 50_000_000,
    parameter int SHOW_CYCLES = 300_000_000,
    parameter int SCORE_W     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic [N_TEAMS-1:0]           team_btn,
    input  logic                         judge_correct,
    input  logic                         judge_wrong,
    input  logic                         score_clr,
    output logic [N_TEAMS-1:0]           led,
    output logic                         winner_valid,
    output logic [$clog2(N_TEAMS)-1:0]   winner_id,
    output logic [N_TEAMS-1:0]           lockout,
    output logic [N_TEAMS*SCORE_W-1:0]   scores
);

    localparam int             IDW       = $clog2(N_TEAMS);
    localparam int             SCW       = cnt_w(SHOW_CYCLES);
    localparam logic [SCW-1:0] SHOW_LAST = SCW'(SHOW_CYCLES - 1);

    logic [1:0]                 state_q,    state_d;
    logic [SCW-1:0]             show_cnt_q, show_cnt_d;
    logic [N_TEAMS-1:0]         led_q,      led_d;
    logic [IDW-1:0]             wid_q,      wid_d;
    logic [N_TEAMS-1:0]         lock_q,     lock_d;
    logic [N_TEAMS*SCORE_W-1:0] scores_q,   scores_d;

    logic [N_TEAMS-1:0]         qual;
    logic                       any_qual;
    logic [IDW-1:0]             win_idx;
    logic [N_TEAMS-1:0]         lock_wrong;
    logic                       show_exit;

    // One hold counter per team; only IDLE, unlocked teams may accumulate.
    for (genvar g = 0; g < N_TEAMS; g++) begin : g_qual
        press_qualifier #(
            .HOLD_CYCLES (HOLD_CYCLES)
        ) u_press_qualifier (
            .clk       (clk),
            .rst_n     (rst_n),
            .en_i      ((state_q == ST_IDLE) && !lock_q[g] && !score_clr),
            .btn_i     (team_btn[g]),
            .qualify_o (qual[g])
        );
    end

    // Lowest-index qualifier wins a same-cycle tie.
    always_comb begin
        any_qual = 1'b0;
        win_idx  = '0;
        for (int i = N_TEAMS - 1; i >= 0; i--) begin
            if (qual[i]) begin
                any_qual = 1'b1;
                win_idx  = IDW'(i);
            end
        end
    end

    // A wrong answer locks the winner out, unless that would bar everyone.
    assign lock_wrong = lock_q | led_q;

    // Next-state logic; score_clr overrides any verdict or state.
    always_comb begin
        state_d    = state_q;
        show_cnt_d = '0;
        led_d      = led_q;
        wid_d      = wid_q;
        lock_d     = lock_q;
        scores_d   = scores_q;
        show_exit  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (any_qual) begin
                    state_d        = ST_SHOW;
                    led_d          = '0;
                    led_d[win_idx] = 1'b1;
                    wid_d          = win_idx;
                end
            end
            ST_SHOW: begin
                show_cnt_d = show_cnt_q + SCW'(1);
                if (judge_correct) begin
                    for (int i = 0; i < N_TEAMS; i++) begin
                        if (IDW'(i) == wid_q) begin
                            scores_d[i*SCORE_W +: SCORE_W] =
                                SCORE_W'(sat_inc(32'(scores_q[i*SCORE_W +: SCORE_W]), SCORE_W));
                        end
                    end
                    lock_d    = '0;
                    show_exit = 1'b1;
                end else if (judge_wrong) begin
                    lock_d    = (&lock_wrong) ? '0 : lock_wrong;
                    show_exit = 1'b1;
                end else if (show_cnt_q == SHOW_LAST) begin
                    show_exit = 1'b1;
                end
                if (show_exit) begin
                    state_d    = ST_RELEASE;
                    show_cnt_d = '0;
                    led_d      = '0;
                    wid_d      = '0;
                end
            end
            ST_RELEASE: begin
                if (team_btn == '0) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (score_clr) begin
            state_d    = ST_IDLE;
            show_cnt_d = '0;
            led_d      = '0;
            wid_d      = '0;
            lock_d     = '0;
            scores_d   = '0;
        end
    end

    // State, winner display, lockout and score registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            show_cnt_q <= '0;
            led_q      <= '0;
            wid_q      <= '0;
            lock_q     <= '0;
            scores_q   <= '0;
        end else begin
            state_q    <= state_d;
            show_cnt_q <= show_cnt_d;
            led_q      <= led_d;
            wid_q      <= wid_d;
            lock_q     <= lock_d;
            scores_q   <= scores_d;
        end
    end

    assign led          = led_q;
    assign winner_valid = (state_q == ST_SHOW);
    assign winner_id    = wid_q;
    assign lockout      = lock_q;
    assign scores       = scores_q;

endmodule
